// File: rtl/ascon_params_pkg.sv
// Shared parameters, FSM state type and round-constant helper for the
// word-serial Ascon permutation datapath and its sequencer.
package ascon_params;

    localparam int WORD_SIZE  = 64;
    localparam int NUM_WORDS  = 5;
    localparam int MAX_ROUNDS = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SBOX = 2'd1,
        LIN  = 2'd2,
        DONE = 2'd3
    } perm_state_e;

    // Upper nibble counts down from 15 while the lower nibble counts up from 0.
    function automatic logic [7:0] round_const_f(input logic [3:0] k);
        round_const_f = {4'(4'd15 - k), k};
    endfunction

endpackage

// File: rtl/ascon_round_cnt.sv
// Round index k and word index w for the permutation sequencer, including
// the clamp of the requested round count and last-round/last-word flags.
module ascon_round_cnt #(
    parameter int NUM_WORDS  = ascon_params::NUM_WORDS,
    parameter int MAX_ROUNDS = ascon_params::MAX_ROUNDS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_i,
    input  logic [3:0] rounds_i,
    input  logic       clr_i,
    input  logic       clr_w_i,
    input  logic       adv_w_i,
    output logic [3:0] k_o,
    output logic [2:0] w_o,
    output logic       last_round_o,
    output logic       last_word_o
);

    localparam logic [3:0] MAX_R  = 4'(MAX_ROUNDS);
    localparam logic [3:0] LAST_K = 4'(MAX_ROUNDS - 1);
    localparam logic [2:0] LAST_W = 3'(NUM_WORDS - 1);

    logic [3:0] k_q, k_d;
    logic [2:0] w_q, w_d;
    logic [3:0] r_clamped;

    // Zero or out-of-range requests fall back to the full p^a round count.
    always_comb begin
        r_clamped = rounds_i;
        if (rounds_i == 4'd0 || rounds_i > MAX_R) begin
            r_clamped = MAX_R;
        end
    end

    assign last_round_o = (k_q == LAST_K);
    assign last_word_o  = (w_q == LAST_W);
    assign k_o          = k_q;
    assign w_o          = w_q;

    always_comb begin
        k_d = k_q;
        w_d = w_q;
        if (load_i) begin
            k_d = MAX_R - r_clamped;
            w_d = '0;
        end else if (clr_i) begin
            k_d = '0;
            w_d = '0;
        end else if (clr_w_i) begin
            w_d = '0;
        end else if (adv_w_i) begin
            if (last_word_o) begin
                w_d = '0;
                if (!last_round_o) begin
                    k_d = k_q + 4'd1;
                end
            end else begin
                w_d = w_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_q <= '0;
            w_q <= '0;
        end else begin
            k_q <= k_d;
            w_q <= w_d;
        end
    end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Sequencer for the word-serial Ascon permutation: S-box step then one linear
// step per word, per round. Optional abort port enabled by ASCON_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start; all datapath controls low
// SBOX  | constant addition + S-box, all words load in parallel
// LIN   | linear layer on word w, one word per cycle
// DONE  | one-cycle completion pulse
module ascon_perm_ctrl #(
    parameter int NUM_WORDS  = ascon_params::NUM_WORDS,
    parameter int MAX_ROUNDS = ascon_params::MAX_ROUNDS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [3:0]           rounds,
`ifdef ASCON_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 sbox_en,
    output logic [2:0]           lin_sel,
    output logic [NUM_WORDS-1:0] load,
    output logic [7:0]           round_const
);

    import ascon_params::*;

    perm_state_e state_q, state_d;

    logic       abort_act;
    logic       accept;
    logic [3:0] k;
    logic [2:0] w;
    logic       last_round;
    logic       last_word;

`ifdef ASCON_ABORT_EN
    assign abort_act = abort;
`else
    assign abort_act = 1'b0;
`endif

    ascon_round_cnt #(
        .NUM_WORDS  (NUM_WORDS),
        .MAX_ROUNDS (MAX_ROUNDS)
    ) u_round_cnt (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (accept),
        .rounds_i     (rounds),
        .clr_i        (state_d == IDLE),
        .clr_w_i      (state_q == SBOX),
        .adv_w_i      (state_q == LIN),
        .k_o          (k),
        .w_o          (w),
        .last_round_o (last_round),
        .last_word_o  (last_word)
    );

    // Abort outranks every transition, and a start in the same cycle is dropped.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (abort_act && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort_act) begin
                        accept  = 1'b1;
                        state_d = SBOX;
                    end
                end
                SBOX: state_d = LIN;
                LIN: begin
                    if (last_word) begin
                        state_d = last_round ? DONE : SBOX;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode registered state only, so inputs never reach them combinationally.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        sbox_en     = 1'b0;
        lin_sel     = '0;
        load        = '0;
        round_const = '0;
        case (state_q)
            SBOX: begin
                busy        = 1'b1;
                sbox_en     = 1'b1;
                load        = '1;
                round_const = round_const_f(k);
            end
            LIN: begin
                busy        = 1'b1;
                lin_sel     = w;
                load        = {{(NUM_WORDS-1){1'b0}}, 1'b1} << w;
                round_const = round_const_f(k);
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl: queue-based run model plus
// directed literal checks; abort scenario built when ASCON_ABORT_EN is set.
module tb_ascon_perm_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] rounds = 4'd0;
    logic       abort = 1'b0;
    logic       busy, done, sbox_en;
    logic [2:0] lin_sel;
    logic [4:0] load;
    logic [7:0] round_const;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ascon_perm_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .rounds      (rounds),
`ifdef ASCON_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy),
        .done        (done),
        .sbox_en     (sbox_en),
        .lin_sel     (lin_sel),
        .load        (load),
        .round_const (round_const)
    );

    // {busy, done, sbox_en, lin_sel[2:0], load[4:0], round_const[7:0]}
    typedef logic [19:0] vec_t;

    vec_t exp_q[$];
    vec_t exp_cur = '0;

    function automatic vec_t mk(input bit b, input bit d, input bit s,
                                input int lin, input int ld, input int rc);
        return {b, d, s, 3'(lin), 5'(ld), 8'(rc)};
    endfunction

    // Whole run expanded up front from the round count.
    task automatic push_run(input int req);
        int r;
        r = (req == 0 || req > 12) ? 12 : req;
        for (int i = 0; i < r; i++) begin
            int kk;
            int rc;
            kk = 12 - r + i;
            rc = (15 - kk) * 16 + kk;
            exp_q.push_back(mk(1, 0, 1, 0, 31, rc));
            for (int j = 0; j < 5; j++) exp_q.push_back(mk(1, 0, 0, j, 1 << j, rc));
        end
        exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            exp_cur = '0;
        end else if (abort && exp_cur != '0) begin
            exp_q.delete();
            exp_cur = '0;
        end else begin
            if (exp_cur == '0 && exp_q.size() == 0 && start && !abort) push_run(int'(rounds));
            exp_cur = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        end
    end

    always @(negedge clk) begin
        vec_t act;
        if (reset_n) begin
            act = {busy, done, sbox_en, lin_sel, load, round_const};
            total++;
            if (act !== exp_cur) begin
                bad++;
                $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act, exp_cur);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_cur != '0 || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic run_dir(input string nm, input int r, input int rc0,
                           input int done_at, input bit poke);
        int cyc, loads, ones, last_rc, first_rc, eff;
        bit seen;
        cyc = 0; loads = 0; ones = 0; last_rc = 0; first_rc = -1; seen = 0;
        eff = (r == 0 || r > 12) ? 12 : r;
        start = 1'b1;
        rounds = 4'(r);
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (poke && cyc == 10) start = 1'b1;
            if (cyc == 1) first_rc = int'(round_const);
            if (load != '0) begin
                loads++;
                last_rc = int'(round_const);
            end
            if (load == '1) ones++;
            if (done) begin
                seen = 1;
                if (poke) start = 1'b1;
            end
        end
        if (!seen) chk({nm, "_timeout"}, 0, 1);
        chk({nm, "_first_rc"}, 32'(first_rc), 32'(rc0));
        chk({nm, "_done_cycle"}, 32'(cyc), 32'(done_at));
        chk({nm, "_loads"}, 32'(loads), 32'(6 * eff));
        chk({nm, "_sbox_loads"}, 32'(ones), 32'(eff));
        chk({nm, "_last_rc"}, 32'(last_rc), 32'h4B);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        if (poke) chk({nm, "_no_rerun"}, {31'd0, busy}, 0);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, d1, s2, d2;
        #1;
        chk("reset_state", {busy, done, sbox_en, lin_sel, load, round_const}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_dir("r12", 12, 32'hF0, 73, 1'b1);
        run_dir("r6", 6, 32'h96, 37, 1'b0);
        run_dir("r8", 8, 32'hB4, 49, 1'b0);
        run_dir("r0", 0, 32'hF0, 73, 1'b0);
        run_dir("r15", 15, 32'hF0, 73, 1'b1);

        // Back-to-back with start held high.
        start = 1'b1;
        rounds = 4'd1;
        c = 0; d1 = -1; s2 = -1; d2 = -1;
        while (d2 < 0 && c < 100) begin
            @(negedge clk);
            c++;
            if (done && d1 < 0) d1 = c;
            else if (sbox_en && d1 >= 0 && s2 < 0) s2 = c;
            else if (done && s2 >= 0) d2 = c;
        end
        start = 1'b0;
        chk("b2b_gap", 32'(s2 - d1), 2);
        chk("b2b_period", 32'(d2 - d1), 8);
        wait_idle();

        // Asynchronous reset in the middle of a LIN phase.
        start = 1'b1;
        rounds = 4'd12;
        repeat (9) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_reset_busy", {31'd0, busy}, 1);
        #2 reset_n = 1'b0;
        #1 chk("reset_async", {busy, done, sbox_en, lin_sel, load, round_const}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", {31'd0, busy}, 0);

`ifdef ASCON_ABORT_EN
        start = 1'b1;
        rounds = 4'd6;
        for (int cy = 1; cy <= 13; cy++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (cy == 10) abort = 1'b1;
            if (cy == 11) chk("abort_idle", {busy, done, sbox_en, load}, 0);
            if (cy == 12) begin
                chk("abort_no_done", {31'd0, done}, 0);
                start = 1'b1;
            end
            if (cy == 13) begin
                chk("restart_sbox", {31'd0, sbox_en}, 1);
                chk("restart_rc", {24'd0, round_const}, 32'h96);
            end
        end
        wait_idle();
`endif

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            rounds = 4'($urandom_range(0, 15));
`ifdef ASCON_ABORT_EN
            abort = ($urandom_range(0, 40) == 0);
`endif
        end
        start = 1'b0;
        abort = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
